// File: rtl/video_pkg.sv
// video_pkg: shared types and 74.25 MHz defaults for video_mode_ctrl.
package video_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEASURE   = 3'd1,
    BLANK     = 3'd2,
    RESET_GEN = 3'd3,
    SETTLE    = 3'd4,
    RUN       = 3'd5
  } vmc_state_t;

  typedef struct packed {
    logic is60;
    logic vga;
  } vmc_mode_t;

  localparam int unsigned STABLE_FRAMES_DEF = 4;
  localparam int unsigned SETTLE_FRAMES_DEF = 2;
  localparam int unsigned RESET_CYCLES_DEF  = 16;
  localparam int unsigned PERIOD_SPLIT_DEF  = 1361250;
  localparam int unsigned PERIOD_MAX_DEF    = 2000000;
  localparam int unsigned LINES_VGA_MIN_DEF = 400;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus edge flop, rising-edge pulse out.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic [2:0] s;

  always_ff @(posedge clk) begin
    if (reset) s <= '0;
    else       s <= {s[1:0], d};
  end

  assign rise = s[1] & ~s[2];
endmodule

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: input mode detection and clean 50/60/VGA switching.
// Define VIDEO_MODE_CTRL_PASSTHRU_EN to build line counting and VGA passthrough.
module video_mode_ctrl
  import video_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = STABLE_FRAMES_DEF,
  parameter int unsigned SETTLE_FRAMES = SETTLE_FRAMES_DEF,
  parameter int unsigned RESET_CYCLES  = RESET_CYCLES_DEF,
  parameter int unsigned PERIOD_SPLIT  = PERIOD_SPLIT_DEF,
  parameter int unsigned PERIOD_MAX    = PERIOD_MAX_DEF,
  parameter int unsigned LINES_VGA_MIN = LINES_VGA_MIN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pal_hsync,
  input  logic        i_pal_vsync,
  input  logic        i_hd_vsync,
  output logic        o_sel_60hz,
  output logic        o_passthrough,
  output logic        o_gen_reset,
  output logic        o_blank,
  output logic        o_mode_valid,
  output logic [10:0] o_line_count,
  output logic [2:0]  o_state
);
  localparam logic [20:0] P_MAX    = 21'(PERIOD_MAX);
  localparam logic [20:0] P_SPLIT  = 21'(PERIOD_SPLIT);
  localparam logic [20:0] RST_LAST = 21'(RESET_CYCLES - 1);
  localparam logic [20:0] SET_LAST = 21'(SETTLE_FRAMES - 1);
  localparam logic [7:0]  STABLE   = 8'(STABLE_FRAMES);

  vmc_state_t  state, state_n;
  vmc_mode_t   cand, cand_q, target, committed;
  logic [20:0] period_cnt, wait_cnt;
  logic [7:0]  stab;
  logic        hs_rise, vs_rise, hd_q, hd_rise;
  logic        cls_vld, accept, timeout, cand_vga;
  logic        blank_d, valid_d, gen_d, load_sel, load_tgt;

  sync_edge_det u_hs (
    .clk   (clk),
    .reset (reset),
    .d     (i_pal_hsync),
    .rise  (hs_rise)
  );

  sync_edge_det u_vs (
    .clk   (clk),
    .reset (reset),
    .d     (i_pal_vsync),
    .rise  (vs_rise)
  );

  assign timeout   = (period_cnt == P_MAX) && (state != IDLE);
  assign hd_rise   = i_hd_vsync & ~hd_q;
  assign accept    = cls_vld && (stab == STABLE);
  assign cand      = '{is60: (period_cnt < P_SPLIT), vga: cand_vga};
  assign committed = '{is60: o_sel_60hz, vga: o_passthrough};
  assign o_state   = state;

  always_ff @(posedge clk) begin
    if (reset)                    period_cnt <= '0;
    else if (vs_rise)             period_cnt <= '0;
    else if (period_cnt != P_MAX) period_cnt <= period_cnt + 21'd1;
  end

`ifdef VIDEO_MODE_CTRL_PASSTHRU_EN
  logic [10:0] lines;

  always_ff @(posedge clk) begin
    if (reset) begin
      lines        <= '0;
      o_line_count <= '0;
    end else if (vs_rise) begin
      lines        <= '0;
      o_line_count <= lines;
    end else if (hs_rise && lines != '1) begin
      lines <= lines + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         o_passthrough <= 1'b0;
    else if (load_sel) o_passthrough <= target.vga;
  end

  assign cand_vga = lines > 11'(LINES_VGA_MIN);
`else
  logic unused_vga;

  assign unused_vga    = hs_rise ^ target.vga;
  assign cand_vga      = 1'b0;
  assign o_passthrough = 1'b0;
  assign o_line_count  = '0;
`endif

  // A timeout outranks a classification landing on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q  <= '0;
      stab    <= '0;
      cls_vld <= 1'b0;
    end else begin
      cls_vld <= vs_rise;
      if (vs_rise) begin
        cand_q <= cand;
        if (cand != cand_q)     stab <= 8'd1;
        else if (stab != STABLE) stab <= stab + 8'd1;
      end
      if (timeout) stab <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hd_q <= 1'b0;
    else       hd_q <= i_hd_vsync;
  end

  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if (state_n != state)
      wait_cnt <= '0;
    else if ((state != SETTLE || hd_rise) && wait_cnt != '1)
      wait_cnt <= wait_cnt + 21'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (vs_rise) state_n = MEASURE;
      MEASURE:
        if (timeout)     state_n = IDLE;
        else if (accept) state_n = BLANK;
      BLANK:
        if (timeout) state_n = IDLE;
        else if (hd_rise || wait_cnt == P_MAX - 21'd1)
          state_n = RESET_GEN;
      RESET_GEN:
        if (timeout)                    state_n = IDLE;
        else if (wait_cnt == RST_LAST) state_n = SETTLE;
      SETTLE:
        if (timeout) state_n = IDLE;
        else if (hd_rise && wait_cnt == SET_LAST)
          state_n = RUN;
      RUN:
        if (timeout) state_n = IDLE;
        else if (accept && cand_q != committed)
          state_n = BLANK;
      default:
        state_n = IDLE;
    endcase
  end

  always_comb begin
    blank_d  = (state_n != RUN);
    valid_d  = (state_n == RUN);
    gen_d    = (state_n == RESET_GEN);
    load_sel = (state_n == RESET_GEN) && (state != RESET_GEN);
    load_tgt = (state_n == BLANK) && (state != BLANK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_blank      <= 1'b1;
      o_mode_valid <= 1'b0;
      o_gen_reset  <= 1'b0;
      o_sel_60hz   <= 1'b0;
      target       <= '0;
    end else begin
      o_blank      <= blank_d;
      o_mode_valid <= valid_d;
      o_gen_reset  <= gen_d;
      if (load_sel) o_sel_60hz <= target.is60;
      if (load_tgt) target     <= cand_q;
    end
  end
endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: random 50/60/VGA frame sequences checked
// against a frame-level model (VGA expectations follow the build macro).
module tb_video_mode_ctrl;
  localparam int SPLIT = 400;
  localparam int PMAX  = 800;
  localparam int VMIN  = 20;
  localparam int NSTB  = 4;
  localparam int RCYC  = 16;
  localparam int HD_P  = 60;
`ifdef VIDEO_MODE_CTRL_PASSTHRU_EN
  localparam bit VGA_EN = 1'b1;
`else
  localparam bit VGA_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_pal_hsync = 1'b0;
  logic        i_pal_vsync = 1'b0;
  logic        i_hd_vsync = 1'b0;
  logic        o_sel_60hz, o_passthrough, o_gen_reset;
  logic        o_blank, o_mode_valid;
  logic [10:0] o_line_count;
  logic [2:0]  o_state;

  always #5 clk = ~clk;

  video_mode_ctrl #(
    .STABLE_FRAMES (NSTB),
    .SETTLE_FRAMES (2),
    .RESET_CYCLES  (RCYC),
    .PERIOD_SPLIT  (SPLIT),
    .PERIOD_MAX    (PMAX),
    .LINES_VGA_MIN (VMIN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_pal_hsync   (i_pal_hsync),
    .i_pal_vsync   (i_pal_vsync),
    .i_hd_vsync    (i_hd_vsync),
    .o_sel_60hz    (o_sel_60hz),
    .o_passthrough (o_passthrough),
    .o_gen_reset   (o_gen_reset),
    .o_blank       (o_blank),
    .o_mode_valid  (o_mode_valid),
    .o_line_count  (o_line_count),
    .o_state       (o_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Cycle monitor: gen-reset pulses and select/blank sequencing rules
  bit   mon_on = 1'b0;
  int   pulses = 0, width = 0, last_width = 0, viol = 0;
  logic p_gr = 1'b0, p_sel = 1'b0, p_pt = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (o_gen_reset && !p_gr) begin
        pulses++;
        width = 1;
      end else if (o_gen_reset) begin
        width++;
      end else if (p_gr) begin
        last_width = width;
      end
      if ((o_sel_60hz !== p_sel || o_passthrough !== p_pt) &&
          !(o_gen_reset && !p_gr))
        viol++;
      if (o_blank === o_mode_valid) viol++;
    end
    p_gr  = o_gen_reset;
    p_sel = o_sel_60hz;
    p_pt  = o_passthrough;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int hd_ph = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    hd_ph = (hd_ph + 1) % HD_P;
    i_hd_vsync = (hd_ph < 2);
  endtask

  // Frame-level model: mode of each measured frame, committed mode, phase
  int         prev_p, prev_l, mst, exp_pulses;
  logic [1:0] committed;
  logic [1:0] hist[$];

  function automatic bit locked();
    if (hist.size() < NSTB) return 1'b0;
    for (int i = 1; i < NSTB; i++)
      if (hist[hist.size()-1-i] != hist[hist.size()-1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int p50();
    return int'($urandom_range(700, 430));
  endfunction

  function automatic int p60();
    return int'($urandom_range(370, 250));
  endfunction

  function automatic int lpal();
    return int'($urandom_range(16, 8));
  endfunction

  function automatic int lvga();
    return int'($urandom_range(30, 22));
  endfunction

  task automatic frame(int p, int l, bit rst_mid);
    logic [1:0] c;
    int h, exp_ln;
    bit done;
    c[1] = (prev_p < SPLIT);
    c[0] = VGA_EN && (prev_l > VMIN);
    exp_ln = VGA_EN ? prev_l : 0;
    hist.push_back(c);
    if (mst == 0) mst = 1;
    if (locked() && (mst == 1 || (mst == 2 && c != committed))) begin
      committed = c;
      exp_pulses++;
      mst = 2;
    end
    h = (l > 0) ? p / (l + 1) : p;
    done = 1'b0;
    for (int cyc = 0; cyc < p && !done; cyc++) begin
      i_pal_vsync = (cyc < 4);
      i_pal_hsync = (l > 0) && (cyc / h >= 1) && (cyc / h <= l) &&
                    (cyc % h < 3);
      tick();
      if (rst_mid && o_gen_reset === 1'b1) begin
        done = 1'b1;
        check("sel_at_genrst", o_sel_60hz, committed[1]);
        check("pt_at_genrst", o_passthrough, committed[0]);
        mon_on = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_gen_reset", o_gen_reset, 0);
        check("rst_blank", o_blank, 1);
        check("rst_state", o_state, 0);
        check("rst_mode_valid", o_mode_valid, 0);
        check("rst_sel", o_sel_60hz, 0);
        reset = 1'b0;
        hist.delete();
        mst = 0;
        committed = 2'b00;
      end
    end
    if (rst_mid) begin
      check("genrst_seen", done, 1);
    end else begin
      if (p > PMAX) begin
        hist.delete();
        mst = 0;
      end
      prev_p = p;
      prev_l = l;
      check("state", o_state, (mst == 2) ? 5 : mst);
      check("blank", o_blank, mst != 2);
      check("mode_valid", o_mode_valid, mst == 2);
      check("sel_60hz", o_sel_60hz, committed[1]);
      check("passthrough", o_passthrough, committed[0]);
      check("line_count", o_line_count, exp_ln);
      check("gen_pulses", pulses, exp_pulses);
      check("seq_rules", viol, 0);
      if (exp_pulses > 0) check("gen_width", last_width, RCYC);
    end
  endtask

  initial begin
    hd_ph = int'($urandom_range(HD_P - 1, 0));
    repeat (3) tick();
    check("reset_state", o_state, 0);
    check("reset_blank", o_blank, 1);
    check("reset_valid", o_mode_valid, 0);
    check("reset_gen", o_gen_reset, 0);
    check("reset_sel", o_sel_60hz, 0);
    check("reset_pt", o_passthrough, 0);
    check("reset_lines", o_line_count, 0);
    reset = 1'b0;
    mon_on = 1'b1;
    repeat (30) tick();
    prev_p = 30;
    prev_l = 0;
    mst = 0;
    committed = 2'b00;
    exp_pulses = 0;

    repeat (6) frame(p50(), lpal(), 1'b0);
    repeat (6) frame(p60(), lpal(), 1'b0);
    repeat (6) frame(p60(), lvga(), 1'b0);
    for (int i = 0; i < 8; i++)
      frame((i % 2 == 1) ? p60() : p50(), lpal(), 1'b0);
    repeat (5) frame(p50(), lpal(), 1'b0);
    frame(PMAX + 100, 0, 1'b0);
    repeat (6) frame(p60(), lpal(), 1'b0);
    repeat (4) frame(p50(), lpal(), 1'b0);
    frame(p50(), lpal(), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
